grid_display_scanner: RTL and testbench

- Downstream consumer of the Game block's 64-bit gridOut (8x8 Life grid).
- Double-buffers each new generation and row-multiplexes it onto an 8x8 LED matrix.
- Swaps buffers only at frame boundaries, so the display never tears.
- Also reports the generation count and extinct/stable flags for the top-level status LEDs.

---
 rtl/game_pkg.sv | 10 +
 rtl/row_scan_timer.sv | 60 ++++++
 rtl/grid_display_scanner.sv | 86 ++++++++
 tb/tb_grid_display_scanner.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: grid geometry, cell types and scan states shared by Game and the display scanner.
package game_pkg;
    localparam int GRID_ROWS = 8;
    localparam int GRID_COLS = 8;
    localparam int GRID_W    = 64;

    typedef logic [GRID_W-1:0]    grid_t;
    typedef logic [GRID_COLS-1:0] row_t;
    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} scan_state_t;
endpackage

// File: rtl/row_scan_timer.sv
// row_scan_timer: per-row slot timing (blank then drive) and row index for the LED matrix.
module row_scan_timer
    import game_pkg::scan_state_t;
#(
    parameter int ROW_DWELL = 1000,
    parameter int BLANK     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_start,
    output logic [2:0] o_row,
    output logic       o_idle,
    output logic       o_drive_en,
    output logic       o_frame_end,
    output logic       o_frame_start
);
    localparam int DW = $clog2(ROW_DWELL);

    scan_state_t   r_state;
    logic [DW-1:0] r_dwell;
    logic [2:0]    r_row;
    logic          w_slot_end;

    // dwell runs across blank and drive, so one slot is ROW_DWELL cycles in total
    assign w_slot_end = r_dwell == DW'(ROW_DWELL - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= game_pkg::IDLE;
            r_dwell <= '0;
            r_row   <= '0;
        end else begin
            case (r_state)
                game_pkg::IDLE: if (i_start) begin
                    r_row   <= '0;
                    r_dwell <= '0;
                    r_state <= game_pkg::BLANK;
                end
                game_pkg::BLANK: begin
                    r_dwell <= r_dwell + 1'b1;
                    if (r_dwell == DW'(BLANK - 1)) r_state <= game_pkg::DRIVE;
                end
                game_pkg::DRIVE: if (w_slot_end) begin
                    r_dwell <= '0;
                    r_row   <= r_row + 1'b1;
                    r_state <= game_pkg::BLANK;
                end else begin
                    r_dwell <= r_dwell + 1'b1;
                end
                default: r_state <= game_pkg::IDLE;
            endcase
        end
    end

    assign o_row         = r_row;
    assign o_idle        = r_state == game_pkg::IDLE;
    assign o_drive_en    = r_state == game_pkg::DRIVE;
    assign o_frame_end   = o_drive_en && r_row == 3'd7 && w_slot_end;
    assign o_frame_start = o_drive_en && r_row == 3'd0 && r_dwell == DW'(BLANK);
endmodule

// File: rtl/grid_display_scanner.sv
// grid_display_scanner: double-buffers Life generations and row-multiplexes them onto an 8x8 LED matrix,
// with generation count and extinct/stable status.
module grid_display_scanner
    import game_pkg::grid_t, game_pkg::GRID_W;
#(
    parameter int ROW_DWELL = 1000,
    parameter int BLANK     = 2,
    parameter int GEN_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [GRID_W-1:0] grid_in,
    input  logic              grid_valid,
    output logic              grid_ready,
    output logic [7:0]        row_n,
    output logic [7:0]        col,
    output logic              frame_start,
    output logic [GEN_W-1:0]  gen_count,
    output logic              extinct,
    output logic              stable
);
    grid_t            r_pending;
    grid_t            r_display;
    grid_t            r_last;
    logic             r_pending_full;
    logic             r_extinct;
    logic             r_stable;
    logic [GEN_W-1:0] r_gen_count;
    logic [2:0]       w_row;
    logic             w_idle;
    logic             w_drive_en;
    logic             w_frame_end;
    logic             w_accept;
    logic             w_swap;

    row_scan_timer #(.ROW_DWELL(ROW_DWELL), .BLANK(BLANK)) u_timer (
        .clk           (clk),
        .reset         (reset),
        .i_start       (r_pending_full),
        .o_row         (w_row),
        .o_idle        (w_idle),
        .o_drive_en    (w_drive_en),
        .o_frame_end   (w_frame_end),
        .o_frame_start (frame_start)
    );

    assign w_accept = grid_valid && !r_pending_full;
    // the display buffer only changes before the first frame or on the last drive cycle of row 7
    assign w_swap   = r_pending_full && (w_idle || w_frame_end);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending      <= '0;
            r_display      <= '0;
            r_last         <= '0;
            r_pending_full <= 1'b0;
            r_gen_count    <= '0;
            r_extinct      <= 1'b0;
            r_stable       <= 1'b0;
        end else begin
            if (w_swap) begin
                r_display      <= r_pending;
                r_pending_full <= 1'b0;
            end else if (w_accept) begin
                r_pending      <= grid_in;
                r_pending_full <= 1'b1;
            end
            if (w_accept) begin
                r_gen_count <= (r_gen_count == '1) ? r_gen_count : r_gen_count + 1'b1;
                r_extinct   <= grid_in == '0;
                r_stable    <= (r_gen_count != '0) && (grid_in == r_last);
                r_last      <= grid_in;
            end
        end
    end

    always_comb begin
        row_n = w_drive_en ? ~(8'd1 << w_row) : 8'hFF;
        col   = w_drive_en ? r_display[{w_row, 3'b000} +: 8] : 8'h00;
    end

    assign grid_ready = !r_pending_full;
    assign gen_count  = r_gen_count;
    assign extinct    = r_extinct;
    assign stable     = r_stable;
endmodule

// File: tb/tb_grid_display_scanner.sv
// tb_grid_display_scanner: scoreboard bench for the scanner with ROW_DWELL=4, BLANK=1 (GEN_W 16 and 2).
module tb_grid_display_scanner;
    localparam int RD = 4;
    localparam int BL = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] grid_in = '0;
    logic        grid_valid = 1'b0;
    logic        grid_ready, frame_start, extinct, stable;
    logic [7:0]  row_n, col;
    logic [15:0] gen_count;
    logic        s_ready, s_fs, s_ext, s_stb;
    logic [7:0]  s_row_n, s_col;
    logic [1:0]  s_gen;

    int n_checks = 0;
    int n_fail = 0;
    logic [63:0] exp_q[$];

    grid_display_scanner #(.ROW_DWELL(RD), .BLANK(BL), .GEN_W(16)) u_dut (
        .clk(clk), .reset(reset), .grid_in(grid_in), .grid_valid(grid_valid),
        .grid_ready(grid_ready), .row_n(row_n), .col(col), .frame_start(frame_start),
        .gen_count(gen_count), .extinct(extinct), .stable(stable)
    );

    grid_display_scanner #(.ROW_DWELL(RD), .BLANK(BL), .GEN_W(2)) u_sat (
        .clk(clk), .reset(reset), .grid_in(grid_in), .grid_valid(grid_valid),
        .grid_ready(s_ready), .row_n(s_row_n), .col(s_col), .frame_start(s_fs),
        .gen_count(s_gen), .extinct(s_ext), .stable(s_stb)
    );

    always #5 clk = ~clk;

    task automatic send(input logic [63:0] g);
        int w = 0;
        while (grid_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (grid_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ready: grid_ready=%b required 1", grid_ready);
        end
        grid_in = g;
        grid_valid = 1'b1;
        @(negedge clk);
        grid_valid = 1'b0;
        exp_q.push_back(g);
    endtask

    // captures one full frame starting at the next frame_start; bad flags any timing/pattern error
    task automatic grab_frame(output logic [63:0] f, output int waited, output bit bad);
        bad = 0;
        f = '0;
        waited = 0;
        while (frame_start !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (frame_start !== 1'b1) begin
            bad = 1;
            return;
        end
        for (int c = 0; c < 8 * RD; c++) begin
            int r;
            int ph;
            r = c / RD;
            ph = c % RD;
            if (c != 0) @(negedge clk);
            if (frame_start !== (c == 0)) bad = 1;
            if (ph < RD - BL) begin
                if (row_n !== ~(8'd1 << r)) bad = 1;
                if (ph == 0) f[8*r +: 8] = col;
                else if (col !== f[8*r +: 8]) bad = 1;
            end else if (row_n !== 8'hFF || col !== 8'h00) bad = 1;
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (row_n !== 8'hFF || col !== 8'h00 || grid_ready !== 1'b1 || gen_count !== 16'd0 ||
                frame_start !== 1'b0 || extinct !== 1'b0 || stable !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state: row_n=%h col=%h ready=%b gen=%0d fs=%b ext=%b stb=%b required FF 00 1 0 0 0 0",
                         row_n, col, grid_ready, gen_count, frame_start, extinct, stable);
            end
        end
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (row_n !== 8'hFF || frame_start !== 1'b0 || grid_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL idle_hold: row_n=%h fs=%b ready=%b required FF 0 1", row_n, frame_start, grid_ready);
            end
        end
    endtask

    task automatic test_first_grid;
        logic [63:0] f;
        int w;
        bit bad;
        send(64'h0000_0000_0000_00A5);
        n_checks++;
        if (gen_count !== 16'd1 || extinct !== 1'b0) begin
            n_fail++;
            $display("FAIL first_status: gen=%0d ext=%b required 1 0", gen_count, extinct);
        end
        @(negedge clk);
        n_checks++;
        if (row_n !== 8'hFF || frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL first_blank: row_n=%h fs=%b required FF 0", row_n, frame_start);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (row_n !== 8'hFE || col !== 8'hA5 || frame_start !== (i == 0)) begin
                n_fail++;
                $display("FAIL first_row0[%0d]: row_n=%h col=%h fs=%b required FE A5 %0d", i, row_n, col, frame_start, i == 0);
            end
        end
        @(negedge clk);
        n_checks++;
        if (row_n !== 8'hFF || col !== 8'h00) begin
            n_fail++;
            $display("FAIL row_gap: row_n=%h col=%h required FF 00", row_n, col);
        end
        @(negedge clk);
        n_checks++;
        if (row_n !== 8'hFD || col !== 8'h00) begin
            n_fail++;
            $display("FAIL first_row1: row_n=%h col=%h required FD 00", row_n, col);
        end
        grab_frame(f, w, bad);
        n_checks++;
        if (w != 8 * RD - RD || bad) begin
            n_fail++;
            $display("FAIL frame_period: waited=%0d bad=%0d required %0d 0", w, bad, 8 * RD - RD);
        end
        n_checks++;
        if (f !== exp_q[0]) begin
            n_fail++;
            $display("FAIL frame_a5: got %h required %h", f, exp_q[0]);
        end
        void'(exp_q.pop_front());
    endtask

    task automatic test_backpressure;
        logic [63:0] f;
        logic [7:0] prev_row_n;
        int w;
        int n;
        bit bad;
        bit seen7;
        repeat (10) @(negedge clk);
        send(64'hFF00_0000_0000_0000);
        seen7 = 0;
        prev_row_n = row_n;
        grid_in = 64'h0000_0000_0000_3C3C;
        grid_valid = 1'b1;
        n = 0;
        while (grid_ready !== 1'b1 && n < 100) begin
            if (row_n === 8'h7F) begin
                seen7 = 1;
                n_checks++;
                if (col !== 8'h00) begin
                    n_fail++;
                    $display("FAIL old_row7: col=%h required 00", col);
                end
            end
            prev_row_n = row_n;
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (grid_ready !== 1'b1 || !seen7 || prev_row_n !== 8'h7F || row_n !== 8'hFF) begin
            n_fail++;
            $display("FAIL ready_at_boundary: ready=%b seen7=%0d prev_row_n=%h row_n=%h required 1 1 7F FF",
                     grid_ready, seen7, prev_row_n, row_n);
        end
        @(negedge clk);
        grid_valid = 1'b0;
        exp_q.push_back(64'h0000_0000_0000_3C3C);
        n_checks++;
        if (frame_start !== 1'b1 || gen_count !== 16'd3 || grid_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL g3_accept: fs=%b gen=%0d ready=%b required 1 3 0", frame_start, gen_count, grid_ready);
        end
        grab_frame(f, w, bad);
        n_checks++;
        if (f !== exp_q[0] || bad || w != 0) begin
            n_fail++;
            $display("FAIL frame_g2: got %h bad=%0d wait=%0d required %h 0 0", f, bad, w, exp_q[0]);
        end
        void'(exp_q.pop_front());
        grab_frame(f, w, bad);
        n_checks++;
        if (f !== exp_q[0] || bad || w != 1) begin
            n_fail++;
            $display("FAIL frame_g3: got %h bad=%0d wait=%0d required %h 0 1", f, bad, w, exp_q[0]);
        end
        void'(exp_q.pop_front());
    endtask

    task automatic test_stable_extinct;
        logic [63:0] f;
        int w;
        bit bad;
        send(64'h1818);
        n_checks++;
        if (stable !== 1'b0 || extinct !== 1'b0) begin
            n_fail++;
            $display("FAIL stable_first: stb=%b ext=%b required 0 0", stable, extinct);
        end
        send(64'h1818);
        n_checks++;
        if (stable !== 1'b1 || extinct !== 1'b0 || gen_count !== 16'd5) begin
            n_fail++;
            $display("FAIL stable_second: stb=%b ext=%b gen=%0d required 1 0 5", stable, extinct, gen_count);
        end
        send(64'h0);
        n_checks++;
        if (stable !== 1'b0 || extinct !== 1'b1) begin
            n_fail++;
            $display("FAIL extinct: stb=%b ext=%b required 0 1", stable, extinct);
        end
        w = 0;
        while (grid_ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        grab_frame(f, w, bad);
        n_checks++;
        if (f !== exp_q[0] || bad) begin
            n_fail++;
            $display("FAIL frame_extinct: got %h bad=%0d required %h 0", f, bad, exp_q[0]);
        end
        void'(exp_q.pop_front());
    endtask

    task automatic test_saturation;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        for (int i = 1; i <= 5; i++) begin
            send(64'h0101 * i);
            n_checks++;
            if (gen_count !== 16'(i) || s_gen !== 2'((i > 3) ? 3 : i)) begin
                n_fail++;
                $display("FAIL gen_sat[%0d]: gen16=%0d gen2=%0d required %0d %0d", i, gen_count, s_gen, i, (i > 3) ? 3 : i);
            end
        end
    endtask

    task automatic test_mid_reset;
        int w = 0;
        while (row_n !== 8'hEF && w < 200) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (row_n !== 8'hEF) begin
            n_fail++;
            $display("FAIL reach_row4: row_n=%h required EF", row_n);
        end
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if (row_n !== 8'hFF || col !== 8'h00 || gen_count !== 16'd0 || grid_ready !== 1'b1 || s_row_n !== 8'hFF) begin
            n_fail++;
            $display("FAIL async_reset: row_n=%h col=%h gen=%0d ready=%b s_row_n=%h required FF 00 0 1 FF",
                     row_n, col, gen_count, grid_ready, s_row_n);
        end
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        w = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (row_n !== 8'hFF || frame_start !== 1'b0) w++;
        end
        n_checks++;
        if (w != 0) begin
            n_fail++;
            $display("FAIL idle_after_reset: active cycles=%0d required 0", w);
        end
        send(64'h0000_0000_0000_0042);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (frame_start !== 1'b1 || row_n !== 8'hFE || col !== exp_q[0][7:0]) begin
            n_fail++;
            $display("FAIL restart: fs=%b row_n=%h col=%h required 1 FE %h", frame_start, row_n, col, exp_q[0][7:0]);
        end
        void'(exp_q.pop_front());
    endtask

    initial begin
        test_reset();
        test_first_grid();
        test_backpressure();
        test_stable_extinct();
        test_saturation();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
